// File: rtl/aes_package.sv
// aes_package: shared scheduler state encoding, round-count constants and
// the control bundle driven towards the AES round datapath.
package aes_package;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEY_INIT,
        S_ROUND,
        S_FINAL,
        S_OUT,
        S_DONE
    } aes_sched_state_t;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_256 = 14;

    typedef struct packed {
        logic       key_load;
        logic       round_en;
        logic       key_step_en;
        logic       final_round;
        logic [3:0] round_idx;
    } ctrl_round_t;

endpackage

// File: rtl/aes_sched_counter.sv
// aes_sched_counter: up-counter with sync clear (priority over enable),
// enable, and an equality flag against a terminal value.
module aes_sched_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + W'(1);
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: block/round sequencer for the AES datapath.
// Define AES_SCHED_KEY256_EN to enable AES-256 (NR = 14) via key_len_i.
module aes_round_sched
    import aes_package::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nb_blocks_i,
    input  logic             key_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             load_block_o,
    output logic             key_load_o,
    output logic             round_en_o,
    output logic             key_step_en_o,
    output logic             final_round_o,
    output logic [3:0]       round_idx_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] blocks_done_o
);

    aes_sched_state_t state, state_nxt;
    logic [CNT_W-1:0] nb_q;
    logic [3:0]       nr, rnd_cnt;
    logic             rnd_act, rnd_last, blk_last, take_start;
    ctrl_round_t      ctrl;

    assign take_start = (state == S_IDLE) && start_i;

`ifdef AES_SCHED_KEY256_EN
    logic key256_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        key256_q <= 1'b0;
        else if (clear)      key256_q <= 1'b0;
        else if (take_start) key256_q <= key_len_i;
    end
    assign nr = key256_q ? 4'(AES_NR_256) : 4'(AES_NR_128);
`else
    logic unused_key_len;
    assign unused_key_len = key_len_i;
    assign nr = 4'(AES_NR_128);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        nb_q <= '0;
        else if (clear)      nb_q <= '0;
        else if (take_start) nb_q <= nb_blocks_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_i) state_nxt = (nb_blocks_i == '0) ? S_DONE : S_LOAD;
            S_LOAD:     if (in_valid_i) state_nxt = S_KEY_INIT;
            S_KEY_INIT: state_nxt = S_ROUND;
            S_ROUND:    if (rnd_last) state_nxt = S_FINAL;
            S_FINAL:    state_nxt = S_OUT;
            S_OUT:      if (out_ready_i) state_nxt = blk_last ? S_DONE : S_LOAD;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    // Round index counts only through KEY_INIT/ROUND, so it reads NR in FINAL and 0 elsewhere.
    assign rnd_act = (state == S_KEY_INIT) || (state == S_ROUND);

    aes_sched_counter #(.W(4)) u_round_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear || !rnd_act),
        .en      (rnd_act),
        .term    (nr - 4'd1),
        .cnt     (rnd_cnt),
        .at_term (rnd_last)
    );

    // Terminal is nb-1 so the flag means "this handshake delivers the last block".
    aes_sched_counter #(.W(CNT_W)) u_block_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear || take_start),
        .en      ((state == S_OUT) && out_ready_i),
        .term    (nb_q - CNT_W'(1)),
        .cnt     (blocks_done_o),
        .at_term (blk_last)
    );

    assign ctrl = '{
        key_load:    (state == S_KEY_INIT),
        round_en:    (state == S_ROUND) || (state == S_FINAL),
        key_step_en: (state == S_ROUND) || (state == S_FINAL),
        final_round: (state == S_FINAL),
        round_idx:   rnd_cnt
    };

    assign key_load_o    = ctrl.key_load;
    assign round_en_o    = ctrl.round_en;
    assign key_step_en_o = ctrl.key_step_en;
    assign final_round_o = ctrl.final_round;
    assign round_idx_o   = ctrl.round_idx;
    assign in_ready_o    = (state == S_LOAD);
    assign load_block_o  = in_valid_i && in_ready_o;
    assign out_valid_o   = (state == S_OUT);
    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: transaction-level checks of the scheduler timeline
// from table, random and hand-written job sequences.
module tb_aes_round_sched;

    localparam int CNT_W = 16;

    logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, start_i = 1'b0, key_len_i = 1'b0;
    logic in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [CNT_W-1:0] nb_blocks_i = '0;
    logic in_ready_o, load_block_o, key_load_o, round_en_o, key_step_en_o, final_round_o;
    logic out_valid_o, busy_o, done_o;
    logic [3:0] round_idx_o;
    logic [CNT_W-1:0] blocks_done_o;

    aes_round_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
        .nb_blocks_i(nb_blocks_i), .key_len_i(key_len_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .load_block_o(load_block_o), .key_load_o(key_load_o),
        .round_en_o(round_en_o), .key_step_en_o(key_step_en_o), .final_round_o(final_round_o),
        .round_idx_o(round_idx_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .blocks_done_o(blocks_done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        int nb;
        int kl;
        int dly;
        int stall_blk;
        int stall_len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nr_of(input int kl);
`ifdef AES_SCHED_KEY256_EN
        return (kl != 0) ? 14 : 10;
`else
        return 10;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input int nb, input int kl);
        start_i = 1'b1;
        nb_blocks_i = CNT_W'(nb);
        key_len_i = kl[0];
        #1;
        chk("idle_before_start", {31'b0, busy_o}, 0);
        tick();
        start_i = 1'b0;
        nb_blocks_i = CNT_W'($urandom);
        key_len_i = 1'($urandom);
        #1;
        chk("start_zeroes_count", 32'(blocks_done_o), 0);
        chk("busy_after_start", {31'b0, busy_o}, 1);
    endtask

    task automatic load_step(input int dly);
        repeat (dly) begin
            in_valid_i = 1'b0;
            #1;
            chk("load_wait_ready", {31'b0, in_ready_o}, 1);
            chk("load_wait_noload", {31'b0, load_block_o}, 0);
            tick();
        end
        in_valid_i = 1'b1;
        #1;
        chk("load_strobe", {31'b0, load_block_o}, 1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic rounds(input int nr, input bit poke);
        #1;
        chk("key_init_load", {31'b0, key_load_o}, 1);
        chk("key_init_idx", 32'(round_idx_o), 0);
        chk("key_init_noround", {30'b0, round_en_o, key_step_en_o}, 0);
        tick();
        for (int r = 1; r < nr; r++) begin
            if (poke && r == 3) begin
                start_i = 1'b1;
                nb_blocks_i = 7;
            end
            #1;
            chk("round_strobes", {28'b0, round_en_o, key_step_en_o, final_round_o, key_load_o}, 32'b1100);
            chk("round_idx", 32'(round_idx_o), 32'(r));
            tick();
            start_i = 1'b0;
        end
        #1;
        chk("final_strobes", {29'b0, round_en_o, key_step_en_o, final_round_o}, 32'b111);
        chk("final_idx", 32'(round_idx_o), 32'(nr));
        tick();
    endtask

    task automatic out_step(input int b, input int stall);
        repeat (stall) begin
            out_ready_i = 1'b0;
            #1;
            chk("out_held", {31'b0, out_valid_o}, 1);
            chk("out_held_count", 32'(blocks_done_o), 32'(b));
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        chk("out_valid", {31'b0, out_valid_o}, 1);
        chk("out_idx_zero", 32'(round_idx_o), 0);
        tick();
        out_ready_i = 1'b0;
        #1;
        chk("out_count_step", 32'(blocks_done_o), 32'(b + 1));
        chk("out_drop", {31'b0, out_valid_o}, 0);
    endtask

    task automatic finish_job(input int nb);
        chk("done_pulse", {31'b0, done_o}, 1);
        chk("done_count", 32'(blocks_done_o), 32'(nb));
        chk("done_noready", {31'b0, in_ready_o}, 0);
        tick();
        #1;
        chk("done_single", {30'b0, done_o, busy_o}, 0);
        chk("idle_count_kept", 32'(blocks_done_o), 32'(nb));
    endtask

    task automatic run_job(input int nb, input int kl, input int dly,
                           input int stall_blk, input int stall_len, input bit rnd);
        begin_job(nb, kl);
        for (int b = 0; b < nb; b++) begin
            load_step(rnd ? int'($urandom_range(0, 3)) : (b == 0 ? dly : 0));
            rounds(nr_of(kl), 1'b0);
            out_step(b, rnd ? int'($urandom_range(0, 4)) : (b == stall_blk ? stall_len : 0));
        end
        finish_job(nb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nb: 1, kl: 0, dly: 0, stall_blk: -1, stall_len: 0};
        vecs[1] = '{nb: 3, kl: 0, dly: 0, stall_blk: 1,  stall_len: 5};
        vecs[2] = '{nb: 2, kl: 1, dly: 0, stall_blk: -1, stall_len: 0};
        vecs[3] = '{nb: 0, kl: 0, dly: 0, stall_blk: -1, stall_len: 0};
        vecs[4] = '{nb: 2, kl: 0, dly: 2, stall_blk: 0,  stall_len: 3};
        vecs[5] = '{nb: 1, kl: 1, dly: 1, stall_blk: 0,  stall_len: 1};

        #2;
        chk("reset_outputs", {3'b0, in_ready_o, load_block_o, key_load_o, round_en_o, key_step_en_o,
            final_round_o, round_idx_o, out_valid_o, busy_o, done_o, blocks_done_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_job(vecs[i].nb, vecs[i].kl, vecs[i].dly, vecs[i].stall_blk, vecs[i].stall_len, 1'b0);

        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 0, -1, 0, 1'b1);

        // asynchronous reset while in ROUND with round_idx 5
        begin_job(1, 0);
        load_step(0);
        repeat (5) tick();
        chk("pre_reset_idx", 32'(round_idx_o), 5);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {3'b0, in_ready_o, load_block_o, key_load_o, round_en_o, key_step_en_o,
            final_round_o, round_idx_o, out_valid_o, busy_o, done_o, blocks_done_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            tick();
            chk("post_reset_idle", {30'b0, busy_o, in_ready_o}, 0);
            chk("post_reset_count", 32'(blocks_done_o), 0);
        end

        // clear in OUT, then a start pulse during ROUND of the next job
        begin_job(2, 0);
        load_step(0);
        rounds(nr_of(0), 1'b0);
        out_ready_i = 1'b0;
        #1;
        chk("clear_in_out", {31'b0, out_valid_o}, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) begin
            #1;
            chk("after_clear_quiet", {29'b0, done_o, busy_o, out_valid_o}, 0);
            chk("after_clear_count", 32'(blocks_done_o), 0);
            tick();
        end
        begin_job(1, 0);
        load_step(0);
        rounds(nr_of(0), 1'b1);
        out_step(0, 0);
        finish_job(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
